// File: rtl/pool_pkg.sv
// rtl/pool_pkg.sv - shared pixel type, default sizes and max helper for the max-pool datapath
package pool_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int KERNEL_DIM = 3;
    localparam int WIDE_W     = 32;

    typedef logic [DATA_WIDTH-1:0] pixel_t;
    typedef logic [WIDE_W-1:0]     wide_t;

    // Operands are zero-extended by callers, so any DATA_WIDTH up to WIDE_W compares unsigned.
    function automatic wide_t max_wide(input wide_t a, input wide_t b);
        return (a >= b) ? a : b;
    endfunction

endpackage

// File: rtl/pool_fifo.sv
// rtl/pool_fifo.sv - output queue; push while full is taken only if a pop lands in the same cycle
module pool_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] pop_data,
    output logic                  full,
    output logic                  empty
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [AW:0]           count_q, count_d;
    logic                  do_push, do_pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == (AW+1)'(FIFO_DEPTH));
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/max_pool_unit.sv
// rtl/max_pool_unit.sv - strided max pooling over a streamed window, two-stage compare into an output queue
module max_pool_unit #(
    parameter int DATA_WIDTH = pool_pkg::DATA_WIDTH,
    parameter int KERNEL_DIM = pool_pkg::KERNEL_DIM,
    parameter int ROW_SIZE   = 5,
    parameter int COL_SIZE   = 5,
    parameter int STRIDE     = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                                               clk,
    input  logic                                               rst,
    input  logic [KERNEL_DIM-1:0][KERNEL_DIM-1:0][DATA_WIDTH-1:0] window,
    input  logic                                               valid,
    output logic [DATA_WIDTH-1:0]                              pooled_out,
    output logic                                               out_valid,
    input  logic                                               out_ready,
    output logic                                               frame_done,
    output logic                                               overflow
);
    import pool_pkg::*;

    localparam int CW = (ROW_SIZE > 1) ? $clog2(ROW_SIZE) : 1;
    localparam int RW = (COL_SIZE > 1) ? $clog2(COL_SIZE) : 1;
    localparam int PW = (STRIDE > 1) ? $clog2(STRIDE) : 1;
    localparam logic [CW-1:0] COL_START = CW'(KERNEL_DIM - 1);
    localparam logic [CW-1:0] COL_LAST  = CW'(ROW_SIZE - 1);
    localparam logic [RW-1:0] ROW_START = RW'(KERNEL_DIM - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(COL_SIZE - 1);
    localparam logic [PW-1:0] PH_LAST   = PW'(STRIDE - 1);

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [PW-1:0] cph_q, cph_d, rph_q, rph_d;
    logic          accept, frame_end;
    logic          s1_valid_q, frame_done_q, overflow_q;
    logic [DATA_WIDTH-1:0] rowmax_q [KERNEL_DIM];
    logic [DATA_WIDTH-1:0] rowmax_d [KERNEL_DIM];
    logic [DATA_WIDTH-1:0] pool_max;
    logic          fifo_full, fifo_empty, pop;
    wide_t         row_acc, col_acc;

    // Stride phase counters replace a modulo: phase 0 in both axes marks an aligned window.
    always_comb begin
        col_d     = col_q;
        row_d     = row_q;
        cph_d     = cph_q;
        rph_d     = rph_q;
        frame_end = 1'b0;
        accept    = valid && (col_q >= COL_START) && (cph_q == '0) && (rph_q == '0);
        if (valid) begin
            if (col_q == COL_LAST && row_q == ROW_LAST) begin
                frame_end = 1'b1;
                col_d     = COL_START;
                row_d     = ROW_START;
                cph_d     = '0;
                rph_d     = '0;
            end else if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = row_q + RW'(1);
                cph_d = '0;
                rph_d = (rph_q == PH_LAST) ? '0 : rph_q + PW'(1);
            end else begin
                col_d = col_q + CW'(1);
                if (col_q >= COL_START)
                    cph_d = (cph_q == PH_LAST) ? '0 : cph_q + PW'(1);
            end
        end
    end

    always_comb begin
        row_acc = '0;
        for (int r = 0; r < KERNEL_DIM; r++) begin
            row_acc = wide_t'(window[r][0]);
            for (int c = 1; c < KERNEL_DIM; c++)
                row_acc = max_wide(row_acc, wide_t'(window[r][c]));
            rowmax_d[r] = row_acc[DATA_WIDTH-1:0];
        end
    end

    always_comb begin
        col_acc = wide_t'(rowmax_q[0]);
        for (int r = 1; r < KERNEL_DIM; r++)
            col_acc = max_wide(col_acc, wide_t'(rowmax_q[r]));
        pool_max = col_acc[DATA_WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q        <= COL_START;
            row_q        <= ROW_START;
            cph_q        <= '0;
            rph_q        <= '0;
            s1_valid_q   <= 1'b0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            cph_q        <= cph_d;
            rph_q        <= rph_d;
            s1_valid_q   <= accept;
            frame_done_q <= frame_end;
            if (s1_valid_q && fifo_full && !pop) overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            for (int r = 0; r < KERNEL_DIM; r++) rowmax_q[r] <= rowmax_d[r];
        end
    end

    assign out_valid  = !fifo_empty;
    assign pop        = out_valid && out_ready;
    assign frame_done = frame_done_q;
    assign overflow   = overflow_q;

    pool_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (s1_valid_q),
        .push_data (pool_max),
        .pop       (pop),
        .pop_data  (pooled_out),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_max_pool_unit.sv
// tb/tb_max_pool_unit.sv - scoreboard bench for max_pool_unit on a 5x5 frame, 3x3 kernel, stride 2
module tb_max_pool_unit;
    import pool_pkg::*;

    localparam int K = 3;
    typedef logic [K-1:0][K-1:0][7:0] win_t;

    logic   clk = 1'b0;
    logic   rst;
    win_t   window;
    logic   valid;
    logic   out_ready;
    pixel_t pooled_out;
    logic   out_valid, frame_done, overflow;

    int     n_tests = 0;
    int     n_fail  = 0;
    pixel_t exp_q[$];
    pixel_t mon_e;

    always #5 clk = ~clk;

    max_pool_unit #(
        .DATA_WIDTH (8),
        .KERNEL_DIM (K),
        .ROW_SIZE   (5),
        .COL_SIZE   (5),
        .STRIDE     (2),
        .FIFO_DEPTH (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .window     (window),
        .valid      (valid),
        .pooled_out (pooled_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .frame_done (frame_done),
        .overflow   (overflow)
    );

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_output: got %0h, expected no output", pooled_out);
            end else begin
                mon_e = exp_q.pop_front();
                if (pooled_out !== mon_e) begin
                    n_fail++;
                    $display("FAIL pooled_out: got %0h, expected %0h", pooled_out, mon_e);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic win_t fill(input pixel_t v);
        win_t w;
        for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++) w[r][c] = v;
        return w;
    endfunction

    // Accepted beat indices within a 5x5 frame: positions (2,2),(4,2),(2,4),(4,4).
    function automatic bit is_acc(input int i);
        return (i == 0) || (i == 2) || (i == 10) || (i == 12);
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_beat(input win_t w);
        window = w;
        valid  = 1'b1;
        tick(1);
        valid  = 1'b0;
        window = fill(8'hEE);
    endtask

    task automatic send_range(input int base, input int lo, input int hi, input int gap, input bit expect_out);
        for (int i = lo; i <= hi; i++) begin
            if (expect_out && is_acc(i)) exp_q.push_back(pixel_t'(base + i));
            send_beat(fill(pixel_t'(base + i)));
            tick(gap);
        end
    endtask

    task automatic drain(input string name);
        int cyc = 0;
        while ((exp_q.size() != 0 || out_valid) && cyc < 200) begin
            tick(1);
            cyc++;
        end
        check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
        check({name, "_empty"}, 32'(out_valid), 32'd0);
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        win_t w;
        rst       = 1'b1;
        valid     = 1'b0;
        out_ready = 1'b0;
        window    = fill(8'h00);
        tick(3);
        rst = 1'b0;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_pooled_out", 32'(pooled_out), 32'd0);

        // Back-to-back frame, values equal to beat index
        out_ready = 1'b1;
        send_range(0, 0, 11, 0, 1);
        check("t1_frame_done_early", 32'(frame_done), 32'd0);
        send_range(0, 12, 12, 0, 1);
        check("t1_frame_done", 32'(frame_done), 32'd1);
        tick(1);
        check("t1_frame_done_pulse", 32'(frame_done), 32'd0);
        drain("t1");

        // Max position variations
        w = fill(8'h01);
        w[0][0] = 8'hFF;
        exp_q.push_back(8'hFF);
        send_beat(w);
        send_beat(fill(8'hEE));
        exp_q.push_back(8'h07);
        send_beat(fill(8'h07));
        send_range(0, 3, 9, 0, 1);
        w = fill(8'h20);
        w[2][2] = 8'h78;
        exp_q.push_back(8'h78);
        send_beat(w);
        send_range(0, 11, 11, 0, 1);
        w = fill(8'h20);
        w[2][0] = 8'h90;
        w[1][1] = 8'h90;
        exp_q.push_back(8'h90);
        send_beat(w);
        check("t2_frame_done", 32'(frame_done), 32'd1);
        drain("t2");

        // Overflow: two frames with consumer stalled
        out_ready = 1'b0;
        send_range(0, 0, 12, 0, 1);
        tick(3);
        check("t3_out_valid", 32'(out_valid), 32'd1);
        check("t3_no_overflow_at_4", 32'(overflow), 32'd0);
        send_range(100, 0, 0, 0, 0);
        tick(1);
        check("t3_overflow_at_5", 32'(overflow), 32'd1);
        send_range(100, 1, 12, 0, 0);
        tick(2);
        out_ready = 1'b1;
        drain("t3");
        check("t3_overflow_sticky", 32'(overflow), 32'd1);
        pulse_rst();
        check("t3_overflow_cleared", 32'(overflow), 32'd0);

        // Full queue with a pop in the push cycle
        out_ready = 1'b0;
        send_range(20, 0, 12, 0, 1);
        tick(3);
        send_range(40, 0, 0, 0, 1);
        out_ready = 1'b1;
        send_range(40, 1, 12, 0, 1);
        drain("t4");
        check("t4_no_overflow", 32'(overflow), 32'd0);

        // Reset one cycle after an accepted beat
        send_beat(fill(8'h60));
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(3);
        check("t5_out_valid", 32'(out_valid), 32'd0);
        check("t5_pooled_out", 32'(pooled_out), 32'd0);
        send_range(80, 0, 12, 0, 1);
        check("t5_frame_done", 32'(frame_done), 32'd1);
        drain("t5");

        // Gapped input, one beat in three
        send_range(0, 0, 11, 2, 1);
        send_range(0, 12, 12, 0, 1);
        check("t6_frame_done", 32'(frame_done), 32'd1);
        drain("t6");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/max_pool_unit.md
MAX_POOL_UNIT -- requirements
Module: max_pool_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: pixel width in bits, unsigned.
REQ-002 SHALL have parameter KERNEL_DIM, default 3: pooling window side length.
REQ-003 SHALL have parameter ROW_SIZE, default 5: image width in pixels.
REQ-004 SHALL have parameter COL_SIZE, default 5: image height in pixels.
REQ-005 SHALL have parameter STRIDE, default 2: pooling stride, applied in both dimensions.
REQ-006 SHALL have parameter FIFO_DEPTH, default 4: output queue entries, a power of two.
REQ-007 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-008 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-009 SHALL have port window, input, KERNEL_DIM x KERNEL_DIM x DATA_WIDTH: candidate window as window[row][col], row 0 top, col KERNEL_DIM-1 newest.
REQ-010 SHALL have port valid, input, 1 bit: window holds a new position this cycle; no backpressure.
REQ-011 SHALL have port pooled_out, output, DATA_WIDTH: head of the output queue.
REQ-012 SHALL have port out_valid, output, 1 bit: pooled_out is valid.
REQ-013 SHALL have port out_ready, input, 1 bit: consumer accepts pooled_out.
REQ-014 SHALL have port frame_done, output, 1 bit: one-cycle pulse after the last window of a frame.
REQ-015 SHALL have port overflow, output, 1 bit: sticky flag set when a result is dropped.

Function
REQ-016 SHALL track the position (col, row) of the right column / bottom row of each valid beat; the first beat after reset or frame end is (KERNEL_DIM-1, KERNEL_DIM-1).
REQ-017 SHALL increment col on each valid beat; at col = ROW_SIZE-1, col SHALL wrap to 0 and row SHALL increment.
REQ-018 SHALL accept a beat only when col >= KERNEL_DIM-1, (col-(KERNEL_DIM-1)) mod STRIDE = 0 and (row-(KERNEL_DIM-1)) mod STRIDE = 0; stride phase SHALL be held in counters, not computed with a divider.
REQ-019 SHALL discard non-accepted beats, including windows that straddle a row wrap, without any output side effect.
REQ-020 SHALL, on the beat at (ROW_SIZE-1, COL_SIZE-1), pulse frame_done for exactly one cycle, coincident with that beat's stage-1 edge, and return to the start position.
REQ-021 SHALL register the per-row maxima of an accepted window at edge E (stage 1), then write the maximum of those maxima into the FIFO at edge E+1 (stage 2); out_valid SHALL be visible after E+1 when the queue was empty and out_ready was low.
REQ-022 SHALL use unsigned comparison; ties SHALL resolve to the equal value; no width growth.
REQ-023 SHALL sustain one accepted window per cycle with no bubbles.
REQ-024 SHALL pop the FIFO on out_valid & out_ready; pooled_out SHALL hold stable while out_valid is high and out_ready is low.
REQ-025 SHALL accept a push when the FIFO is full if a pop occurs in the same cycle.
REQ-026 SHALL otherwise drop a push into a full FIFO, leave the contents intact, and set overflow until rst.
REQ-027 SHALL leave an empty FIFO empty on a pop request; pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-028 SHALL, on rst, clear out_valid, frame_done, overflow, pipeline valids, FIFO pointers and count, and the position/phase counters.
REQ-029 SHALL, on rst asserted mid-frame or mid-pipeline, discard in-flight results; pooled_out SHALL read 0 after reset.

Structure
REQ-030 SHALL take DATA_WIDTH, KERNEL_DIM, the pixel_t typedef and max-function helpers from the shared package pool_pkg.
REQ-031 SHALL instantiate the output queue as sub-module pool_fifo (parameters DATA_WIDTH, FIFO_DEPTH; ports push/pop/full/empty).

Verification (ROW_SIZE=5, COL_SIZE=5, KERNEL_DIM=3, STRIDE=2, FIFO_DEPTH=4)
REQ-032 SHALL check: 13 consecutive valid beats with window value = beat index on all 9 cells, out_ready=1 -> outputs 0, 2, 10, 12; frame_done on the 13th beat.
REQ-033 SHALL check: an accepted window with the single 0xFF at [0][0] and all other cells 0x01 -> 0xFF; a second window of all 0x07 -> 0x07.
REQ-034 SHALL check: out_ready=0 for two frames -> 4 outputs queued, overflow=1 after the 5th result, queue holds the first 4 in order.
REQ-035 SHALL check: full FIFO with out_ready=1 on the cycle a push arrives -> no drop, overflow stays 0.
REQ-036 SHALL check: rst asserted one cycle after an accepted beat -> no output appears, and the next frame restarts at (2,2) and yields 4 outputs.
REQ-037 SHALL check: valid gapped 1-in-3 -> the same 4 results as back-to-back streaming.
